id_ex_stage: RTL and testbench

ID/EX pipeline register of the RV32IM_Zbb core: it captures the instruction decoder's control word and the decode-stage operands and presents them to EX one cycle later. It also detects load-use hazards and inserts bubbles, applies branch/jump flushes, and runs the end-of-program halt sequence when an ECALL/EBREAK stop flag reaches EX.

---
 rtl/id_ex_stage.sv | 166 ++++++++++++++++
 tb/tb_id_ex_stage.sv | 276 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/id_ex_stage.sv
// rtl/id_ex_stage.sv - ID/EX pipeline register with load-use bubbles, flush and halt drain
// Optional feature macro: ID_EX_HAZARD_EN (load-use detection; undefined ties lu to 0)
module id_ex_stage #(
    parameter int DRAIN_CYCLES = 3
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        id_valid_i,
    input  logic        flush_i,
    input  logic        mem_to_reg_i,
    input  logic        rd_we_i,
    input  logic        alu_src_b_i,
    input  logic        branch_i,
    input  logic        rs1_in_use_i,
    input  logic        rs2_in_use_i,
    input  logic        stop_flag_i,
    input  logic        pc_operand_i,
    input  logic [3:0]  data_mem_we_i,
    input  logic [1:0]  alu_2bit_op_i,
    input  logic [31:0] pc_i,
    input  logic [31:0] rs1_data_i,
    input  logic [31:0] rs2_data_i,
    input  logic [31:0] imm_i,
    input  logic [4:0]  rs1_addr_i,
    input  logic [4:0]  rs2_addr_i,
    input  logic [4:0]  rd_addr_i,
    input  logic [2:0]  funct3_i,
    input  logic [6:0]  funct7_i,
    output logic        ex_mem_to_reg_o,
    output logic        ex_rd_we_o,
    output logic        ex_alu_src_b_o,
    output logic        ex_branch_o,
    output logic        ex_rs1_in_use_o,
    output logic        ex_rs2_in_use_o,
    output logic        ex_stop_flag_o,
    output logic        ex_pc_operand_o,
    output logic [3:0]  ex_data_mem_we_o,
    output logic [1:0]  ex_alu_2bit_op_o,
    output logic [31:0] ex_pc_o,
    output logic [31:0] ex_rs1_data_o,
    output logic [31:0] ex_rs2_data_o,
    output logic [31:0] ex_imm_o,
    output logic [4:0]  ex_rs1_addr_o,
    output logic [4:0]  ex_rs2_addr_o,
    output logic [4:0]  ex_rd_addr_o,
    output logic [2:0]  ex_funct3_o,
    output logic [6:0]  ex_funct7_o,
    output logic        ex_valid_o,
    output logic        stall_o,
    output logic        halted_o
);

    typedef enum logic [1:0] {
        ST_RUN    = 2'd0,
        ST_DRAIN  = 2'd1,
        ST_HALTED = 2'd2
    } state_t;

    localparam logic [3:0] DRAIN_LOAD = 4'(DRAIN_CYCLES - 1);

    state_t     state_q, state_d;
    logic [3:0] cnt_q, cnt_d;
    logic       lu;
    logic       capture;
    logic       ctl_keep;

`ifdef ID_EX_HAZARD_EN
    assign lu = ex_valid_o & ex_mem_to_reg_o & ex_rd_we_o & (ex_rd_addr_o != 5'd0) & id_valid_i &
                ((rs1_in_use_i & (rs1_addr_i == ex_rd_addr_o)) |
                 (rs2_in_use_i & (rs2_addr_i == ex_rd_addr_o)));
`else
    assign lu = 1'b0;
`endif

    // capture: ID data enters EX; ctl_keep: its controls survive as well
    assign capture  = (state_q == ST_RUN) & ~flush_i & ~lu;
    assign ctl_keep = capture & id_valid_i;

    assign stall_o  = (lu & ~flush_i & (state_q == ST_RUN)) | (state_q != ST_RUN);
    assign halted_o = (state_q == ST_HALTED);

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        case (state_q)
            ST_RUN: begin
                if (ctl_keep & stop_flag_i) begin
                    state_d = ST_DRAIN;
                    cnt_d   = DRAIN_LOAD;
                end
            end
            ST_DRAIN: begin
                if (cnt_q == 4'd0) begin
                    state_d = ST_HALTED;
                end else begin
                    cnt_d = cnt_q - 4'd1;
                end
            end
            ST_HALTED: begin
                state_d = ST_HALTED;
            end
            default: begin
                state_d = ST_RUN;
                cnt_d   = 4'd0;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= ST_RUN;
            cnt_q   <= 4'd0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ex_valid_o       <= 1'b0;
            ex_mem_to_reg_o  <= 1'b0;
            ex_rd_we_o       <= 1'b0;
            ex_alu_src_b_o   <= 1'b0;
            ex_branch_o      <= 1'b0;
            ex_rs1_in_use_o  <= 1'b0;
            ex_rs2_in_use_o  <= 1'b0;
            ex_stop_flag_o   <= 1'b0;
            ex_pc_operand_o  <= 1'b0;
            ex_data_mem_we_o <= 4'd0;
            ex_alu_2bit_op_o <= 2'd0;
            ex_pc_o          <= 32'd0;
            ex_rs1_data_o    <= 32'd0;
            ex_rs2_data_o    <= 32'd0;
            ex_imm_o         <= 32'd0;
            ex_rs1_addr_o    <= 5'd0;
            ex_rs2_addr_o    <= 5'd0;
            ex_rd_addr_o     <= 5'd0;
            ex_funct3_o      <= 3'd0;
            ex_funct7_o      <= 7'd0;
        end else begin
            ex_valid_o       <= ctl_keep;
            ex_mem_to_reg_o  <= ctl_keep & mem_to_reg_i;
            ex_rd_we_o       <= ctl_keep & rd_we_i;
            ex_alu_src_b_o   <= ctl_keep & alu_src_b_i;
            ex_branch_o      <= ctl_keep & branch_i;
            ex_rs1_in_use_o  <= ctl_keep & rs1_in_use_i;
            ex_rs2_in_use_o  <= ctl_keep & rs2_in_use_i;
            ex_stop_flag_o   <= ctl_keep & stop_flag_i;
            ex_pc_operand_o  <= ctl_keep & pc_operand_i;
            ex_data_mem_we_o <= ctl_keep ? data_mem_we_i : 4'd0;
            ex_alu_2bit_op_o <= ctl_keep ? alu_2bit_op_i : 2'd0;
            // data fields follow capture even for an invalid slot; bubbles zero them
            ex_pc_o          <= capture ? pc_i       : 32'd0;
            ex_rs1_data_o    <= capture ? rs1_data_i : 32'd0;
            ex_rs2_data_o    <= capture ? rs2_data_i : 32'd0;
            ex_imm_o         <= capture ? imm_i      : 32'd0;
            ex_rs1_addr_o    <= capture ? rs1_addr_i : 5'd0;
            ex_rs2_addr_o    <= capture ? rs2_addr_i : 5'd0;
            ex_rd_addr_o     <= capture ? rd_addr_i  : 5'd0;
            ex_funct3_o      <= capture ? funct3_i   : 3'd0;
            ex_funct7_o      <= capture ? funct7_i   : 7'd0;
        end
    end

endmodule

// File: tb/tb_id_ex_stage.sv
// tb/tb_id_ex_stage.sv - scoreboard bench for id_ex_stage (follows ID_EX_HAZARD_EN if defined)
module tb_id_ex_stage;

    localparam int DRAIN = 3;
`ifdef ID_EX_HAZARD_EN
    localparam bit HAZ_EN = 1'b1;
`else
    localparam bit HAZ_EN = 1'b0;
`endif

    typedef struct packed {
        logic        halted;
        logic        valid;
        logic        m2r, rdwe, asb, br, r1u, r2u, stop, pco;
        logic [3:0]  dmwe;
        logic [1:0]  aluop;
        logic [31:0] pc, r1d, r2d, imm;
        logic [4:0]  r1a, r2a, rda;
        logic [2:0]  f3;
        logic [6:0]  f7;
    } ex_t;

    typedef struct packed {
        logic        idv, flush;
        logic        m2r, rdwe, asb, br, r1u, r2u, stop, pco;
        logic [3:0]  dmwe;
        logic [1:0]  aluop;
        logic [31:0] pc, r1d, r2d, imm;
        logic [4:0]  r1a, r2a, rda;
        logic [2:0]  f3;
        logic [6:0]  f7;
    } in_t;

    logic clk = 1'b0;
    logic rst_n;
    logic id_valid_i, flush_i, mem_to_reg_i, rd_we_i, alu_src_b_i, branch_i;
    logic rs1_in_use_i, rs2_in_use_i, stop_flag_i, pc_operand_i;
    logic [3:0]  data_mem_we_i;
    logic [1:0]  alu_2bit_op_i;
    logic [31:0] pc_i, rs1_data_i, rs2_data_i, imm_i;
    logic [4:0]  rs1_addr_i, rs2_addr_i, rd_addr_i;
    logic [2:0]  funct3_i;
    logic [6:0]  funct7_i;
    logic ex_mem_to_reg_o, ex_rd_we_o, ex_alu_src_b_o, ex_branch_o;
    logic ex_rs1_in_use_o, ex_rs2_in_use_o, ex_stop_flag_o, ex_pc_operand_o;
    logic [3:0]  ex_data_mem_we_o;
    logic [1:0]  ex_alu_2bit_op_o;
    logic [31:0] ex_pc_o, ex_rs1_data_o, ex_rs2_data_o, ex_imm_o;
    logic [4:0]  ex_rs1_addr_o, ex_rs2_addr_o, ex_rd_addr_o;
    logic [2:0]  ex_funct3_o;
    logic [6:0]  ex_funct7_o;
    logic ex_valid_o, stall_o, halted_o;

    always #5 clk = ~clk;

    id_ex_stage #(.DRAIN_CYCLES(DRAIN)) dut (
        .clk(clk), .rst_n(rst_n), .id_valid_i(id_valid_i), .flush_i(flush_i),
        .mem_to_reg_i(mem_to_reg_i), .rd_we_i(rd_we_i), .alu_src_b_i(alu_src_b_i),
        .branch_i(branch_i), .rs1_in_use_i(rs1_in_use_i), .rs2_in_use_i(rs2_in_use_i),
        .stop_flag_i(stop_flag_i), .pc_operand_i(pc_operand_i), .data_mem_we_i(data_mem_we_i),
        .alu_2bit_op_i(alu_2bit_op_i), .pc_i(pc_i), .rs1_data_i(rs1_data_i),
        .rs2_data_i(rs2_data_i), .imm_i(imm_i), .rs1_addr_i(rs1_addr_i),
        .rs2_addr_i(rs2_addr_i), .rd_addr_i(rd_addr_i), .funct3_i(funct3_i),
        .funct7_i(funct7_i), .ex_mem_to_reg_o(ex_mem_to_reg_o), .ex_rd_we_o(ex_rd_we_o),
        .ex_alu_src_b_o(ex_alu_src_b_o), .ex_branch_o(ex_branch_o),
        .ex_rs1_in_use_o(ex_rs1_in_use_o), .ex_rs2_in_use_o(ex_rs2_in_use_o),
        .ex_stop_flag_o(ex_stop_flag_o), .ex_pc_operand_o(ex_pc_operand_o),
        .ex_data_mem_we_o(ex_data_mem_we_o), .ex_alu_2bit_op_o(ex_alu_2bit_op_o),
        .ex_pc_o(ex_pc_o), .ex_rs1_data_o(ex_rs1_data_o), .ex_rs2_data_o(ex_rs2_data_o),
        .ex_imm_o(ex_imm_o), .ex_rs1_addr_o(ex_rs1_addr_o), .ex_rs2_addr_o(ex_rs2_addr_o),
        .ex_rd_addr_o(ex_rd_addr_o), .ex_funct3_o(ex_funct3_o), .ex_funct7_o(ex_funct7_o),
        .ex_valid_o(ex_valid_o), .stall_o(stall_o), .halted_o(halted_o)
    );

    ex_t obs;
    assign obs = {halted_o, ex_valid_o, ex_mem_to_reg_o, ex_rd_we_o, ex_alu_src_b_o,
                  ex_branch_o, ex_rs1_in_use_o, ex_rs2_in_use_o, ex_stop_flag_o,
                  ex_pc_operand_o, ex_data_mem_we_o, ex_alu_2bit_op_o, ex_pc_o,
                  ex_rs1_data_o, ex_rs2_data_o, ex_imm_o, ex_rs1_addr_o, ex_rs2_addr_o,
                  ex_rd_addr_o, ex_funct3_o, ex_funct7_o};

    int   n_checks = 0;
    int   n_errors = 0;
    ex_t  exp_q[$];
    ex_t  m_ex;
    int   m_state;
    int   m_cnt;

    task automatic chk(input string tag, input logic [199:0] got, input logic [199:0] want);
        n_checks++;
        if (got !== want) begin
            n_errors++;
            $display("FAIL %s: got %h expected %h", tag, got, want);
        end
    endtask

    task automatic apply(input in_t t);
        id_valid_i = t.idv;     flush_i = t.flush;     mem_to_reg_i = t.m2r;
        rd_we_i = t.rdwe;       alu_src_b_i = t.asb;   branch_i = t.br;
        rs1_in_use_i = t.r1u;   rs2_in_use_i = t.r2u;  stop_flag_i = t.stop;
        pc_operand_i = t.pco;   data_mem_we_i = t.dmwe; alu_2bit_op_i = t.aluop;
        pc_i = t.pc;            rs1_data_i = t.r1d;    rs2_data_i = t.r2d;
        imm_i = t.imm;          rs1_addr_i = t.r1a;    rs2_addr_i = t.r2a;
        rd_addr_i = t.rda;      funct3_i = t.f3;       funct7_i = t.f7;
    endtask

    function automatic in_t base();
        in_t t = '0;
        t.idv = 1'b1;
        t.pc  = $urandom;  t.r1d = $urandom;  t.r2d = $urandom;  t.imm = $urandom;
        t.r1a = 5'($urandom); t.r2a = 5'($urandom); t.rda = 5'($urandom);
        t.f3  = 3'($urandom); t.f7 = 7'($urandom);
        return t;
    endfunction

    // one ID cycle: starts and ends at a falling edge
    task automatic step(input in_t t, input string tag);
        bit  lu, want_stall;
        ex_t nx, e;
        apply(t);
        #1;
        lu = HAZ_EN && m_ex.valid && m_ex.m2r && m_ex.rdwe && (m_ex.rda != 0) && t.idv &&
             ((t.r1u && t.r1a == m_ex.rda) || (t.r2u && t.r2a == m_ex.rda));
        want_stall = (lu && !t.flush && m_state == 0) || (m_state != 0);
        chk({tag, ".stall"}, 200'(stall_o), 200'(want_stall));
        nx = '0;
        if (m_state == 0 && !t.flush && !lu) begin
            nx.valid = t.idv;
            nx.pc = t.pc;   nx.r1d = t.r1d; nx.r2d = t.r2d; nx.imm = t.imm;
            nx.r1a = t.r1a; nx.r2a = t.r2a; nx.rda = t.rda; nx.f3 = t.f3; nx.f7 = t.f7;
            if (t.idv) begin
                nx.m2r = t.m2r; nx.rdwe = t.rdwe; nx.asb = t.asb; nx.br = t.br;
                nx.r1u = t.r1u; nx.r2u = t.r2u; nx.stop = t.stop; nx.pco = t.pco;
                nx.dmwe = t.dmwe; nx.aluop = t.aluop;
            end
        end
        if (m_state == 0) begin
            if (nx.stop) begin
                m_state = 1;
                m_cnt   = DRAIN - 1;
            end
        end else if (m_state == 1) begin
            if (m_cnt == 0) m_state = 2;
            else m_cnt = m_cnt - 1;
        end
        nx.halted = (m_state == 2);
        m_ex = nx;
        exp_q.push_back(nx);
        @(posedge clk);
        #1;
        if (exp_q.size() == 0) begin
            chk({tag, ".queue"}, 200'(0), 200'(1));
        end else begin
            e = exp_q.pop_front();
            chk({tag, ".ex"}, 200'(obs), 200'(e));
        end
        @(negedge clk);
    endtask

    // called at a falling edge; asserts reset between clock edges
    task automatic do_reset(input string tag);
        #2 rst_n = 1'b0;
        #1;
        m_ex = '0; m_state = 0; m_cnt = 0;
        exp_q.delete();
        chk({tag, ".async_ex"}, 200'(obs), 200'(m_ex));
        chk({tag, ".async_stall"}, 200'(stall_o), 200'(0));
        @(posedge clk);
        #1;
        chk({tag, ".held_ex"}, 200'(obs), 200'(m_ex));
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    initial begin
        in_t t, ld, add;
        m_ex = '0; m_state = 0; m_cnt = 0;
        rst_n = 1'b0;
        t = base();
        t.f3 = 3'b010;
        apply(t);
        #1;
        chk("reset.ex", 200'(obs), 200'(0));
        chk("reset.stall", 200'(stall_o), 200'(0));
        repeat (2) @(negedge clk);
        chk("reset.held", 200'(obs), 200'(0));
        rst_n = 1'b1;
        step(t, "first_capture");
        chk("first.f3", 200'(ex_funct3_o), 200'(3'b010));

        t = base(); t.rdwe = 1'b1; t.aluop = 2'b10; t.r1d = 32'h1234_5678;
        t.r1u = 1'b1; t.r2u = 1'b1; t.f7 = 7'h00;
        step(t, "rtype");
        chk("rtype.r1d", 200'(ex_rs1_data_o), 200'(32'h1234_5678));

        // load-use: LW x5 then ADD reading x5 through rs2
        ld = base(); ld.m2r = 1'b1; ld.rdwe = 1'b1; ld.asb = 1'b1; ld.r1u = 1'b1;
        ld.r1a = 5'd2; ld.rda = 5'd5; ld.f3 = 3'b010;
        step(ld, "lw_x5");
        add = base(); add.rdwe = 1'b1; add.aluop = 2'b10; add.r1u = 1'b1; add.r2u = 1'b1;
        add.r1a = 5'd1; add.r2a = 5'd5; add.rda = 5'd6;
        step(add, "add_dep");
        step(add, "add_retry");

        // rd=x0 load never stalls
        ld.rda = 5'd0;
        step(ld, "lw_x0");
        add.r1a = 5'd0; add.r2a = 5'd0;
        step(add, "add_x0");

        // back-to-back dependent loads
        ld.rda = 5'd6; ld.r1a = 5'd3;
        step(ld, "lw_x6");
        ld.rda = 5'd7; ld.r1a = 5'd6;
        step(ld, "lw_x7_dep");
        step(ld, "lw_x7_retry");
        add.r1a = 5'd7; add.r2a = 5'd9; add.rda = 5'd10;
        step(add, "add_x7_dep");
        step(add, "add_x7_retry");

        // flush of a store, then flush colliding with a load-use
        t = base(); t.dmwe = 4'b1111; t.r1u = 1'b1; t.r2u = 1'b1; t.flush = 1'b1;
        step(t, "sw_flush");
        ld.rda = 5'd5; ld.r1a = 5'd1;
        step(ld, "lw_x5_b");
        add.r1a = 5'd5; add.r2a = 5'd0; add.flush = 1'b1;
        step(add, "flush_lu");
        add.flush = 1'b0;

        // stop flag killed by flush
        t = base(); t.stop = 1'b1; t.flush = 1'b1;
        step(t, "stop_flush");
        t = base();
        step(t, "after_stop_flush");
        chk("stop_flush.halted", 200'(halted_o), 200'(0));

        // ECALL: drain, flush ignored, sticky halt
        t = base(); t.stop = 1'b1;
        step(t, "ecall");
        t = base(); step(t, "drain1");
        t = base(); t.flush = 1'b1; step(t, "drain2_flush");
        t = base(); step(t, "drain3");
        chk("halt.at_drain", 200'(halted_o), 200'(1));
        t = base(); step(t, "halted1");
        t = base(); step(t, "halted2");
        chk("halt.sticky", 200'(halted_o), 200'(1));

        // reset mid-DRAIN
        do_reset("rst_halted");
        t = base(); t.stop = 1'b1;
        step(t, "ecall2");
        t = base(); step(t, "drain2_1");
        do_reset("rst_drain");
        t = base(); t.rdwe = 1'b1; t.aluop = 2'b10;
        step(t, "after_rst");
        t = base(); step(t, "after_rst2");
        chk("rst_drain.halted", 200'(halted_o), 200'(0));

        // random traffic on a narrow register range
        for (int i = 0; i < 60; i++) begin
            t = base();
            t.idv   = ($urandom_range(0, 4) != 0);
            t.flush = ($urandom_range(0, 5) == 0);
            t.m2r   = 1'($urandom); t.rdwe = 1'($urandom); t.asb = 1'($urandom);
            t.br    = 1'($urandom); t.r1u = 1'($urandom);  t.r2u = 1'($urandom);
            t.pco   = 1'($urandom); t.dmwe = 4'($urandom); t.aluop = 2'($urandom);
            t.r1a   = 5'($urandom_range(0, 3)); t.r2a = 5'($urandom_range(0, 3));
            t.rda   = 5'($urandom_range(0, 3));
            step(t, $sformatf("rand%0d", i));
        end

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
